// File: rtl/cp_port_hub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cp_port_hub: routes CPU coprocessor requests to NUM_CP channels, buffers |
// | returned data in a FIFO and latches per-channel exceptions.              |
// | Optional macro CP_HUB_TIMEOUT_EN adds a WAIT_FDS response timeout.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cp_port_hub #(
  parameter int NUM_CP     = 2,
  parameter int SEL_W      = 1,
  parameter int DATA_W     = 32,
  parameter int EXC_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     cpu_as,
  input  logic                     cpu_ts,
  input  logic                     cpu_fs,
  input  logic [SEL_W-1:0]         cpu_sel,
  input  logic [DATA_W-1:0]        cpu_tdata,
  output logic                     cpu_stall,
  output logic                     cpu_fvalid,
  output logic [DATA_W-1:0]        cpu_fdata,
  input  logic                     cpu_fack,
  output logic                     cpu_exc,
  output logic [SEL_W-1:0]         cpu_exc_ch,
  output logic [EXC_W-1:0]         cpu_exc_code,
  input  logic                     cpu_exc_ack,
  output logic [NUM_CP-1:0]        cp_as,
  output logic [NUM_CP-1:0]        cp_ts,
  output logic [NUM_CP-1:0]        cp_fs,
  output logic [DATA_W-1:0]        cp_tdata,
  input  logic [NUM_CP-1:0]        cp_abusy,
  input  logic [NUM_CP-1:0]        cp_tbusy,
  input  logic [NUM_CP-1:0]        cp_fbusy,
  input  logic [NUM_CP-1:0]        cp_fds,
  input  logic [NUM_CP*DATA_W-1:0] cp_fdata,
  input  logic [NUM_CP-1:0]        cp_exc,
  input  logic [NUM_CP*EXC_W-1:0]  cp_exccode
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_WAIT_FDS = 2'd2;

  localparam logic [1:0] K_AS = 2'd0;
  localparam logic [1:0] K_TS = 2'd1;
  localparam logic [1:0] K_FS = 2'd2;

  logic [1:0]        state_q, state_d, kind_q, kind_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic [NUM_CP-1:0] pend_q, pend_d;
  logic [EXC_W-1:0]  code_q [NUM_CP];
  logic [EXC_W-1:0]  code_d [NUM_CP];

  logic [DATA_W-1:0] fdata_ch [NUM_CP];
  logic [EXC_W-1:0]  exccode_ch [NUM_CP];
  logic [NUM_CP-1:0] ch_oh;
  logic [1:0]        req_kind;
  logic              req, sel_ok, req_busy, fifo_full, push, pop, tmo;

  generate
    for (genvar g = 0; g < NUM_CP; g++) begin : g_unpack
      assign fdata_ch[g]   = cp_fdata[g*DATA_W +: DATA_W];
      assign exccode_ch[g] = cp_exccode[g*EXC_W +: EXC_W];
    end
  endgenerate

  always_comb begin
    req      = cpu_as | cpu_ts | cpu_fs;
    req_kind = cpu_fs ? K_FS : (cpu_ts ? K_TS : K_AS);
    sel_ok   = 32'(cpu_sel) < 32'(NUM_CP);
    req_busy = 1'b0;
    if (sel_ok) begin
      case (req_kind)
        K_FS:    req_busy = cp_fbusy[cpu_sel];
        K_TS:    req_busy = cp_tbusy[cpu_sel];
        default: req_busy = cp_abusy[cpu_sel];
      endcase
    end
    fifo_full = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
    cpu_stall = req && ((state_q != S_IDLE) || !sel_ok || req_busy || (cpu_fs && fifo_full));
  end

`ifdef CP_HUB_TIMEOUT_EN
  logic [15:0] tcnt_q, tcnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    ch_d    = ch_q;
    tdata_d = tdata_q;
    push    = 1'b0;
    tmo     = 1'b0;
`ifdef CP_HUB_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req && !cpu_stall) begin
          state_d = S_DISPATCH;
          kind_d  = req_kind;
          ch_d    = cpu_sel;
          tdata_d = cpu_tdata;
        end
      end
      S_DISPATCH: begin
        if (kind_q == K_FS) begin
`ifdef CP_HUB_TIMEOUT_EN
          tcnt_d = '0;
`endif
          if (cp_fds[ch_q]) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_FDS;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_FDS: begin
        if (cp_fds[ch_q]) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
`ifdef CP_HUB_TIMEOUT_EN
        // Counts completed WAIT_FDS cycles; the TIMEOUT-th one gives up.
        else if (tcnt_q + 16'd1 == 16'(TIMEOUT)) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop   = cpu_fack && cpu_fvalid;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = fdata_ch[ch_q];
    wr_d  = wr_q + PTR_W'(push);
    rd_d  = rd_q + PTR_W'(pop);
    cnt_d = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_comb begin
    cpu_exc      = |pend_q;
    cpu_exc_ch   = '0;
    cpu_exc_code = '0;
    for (int i = NUM_CP - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        cpu_exc_ch   = SEL_W'(i);
        cpu_exc_code = code_q[i];
      end
    end
    pend_d = pend_q;
    code_d = code_q;
    if (cpu_exc_ack && cpu_exc) pend_d[cpu_exc_ch] = 1'b0;
    if (tmo) begin
      pend_d[ch_q] = 1'b1;
      code_d[ch_q] = '1;
    end
    // A fresh exception beats a same-cycle ack on its channel.
    for (int i = 0; i < NUM_CP; i++) begin
      if (cp_exc[i]) begin
        pend_d[i] = 1'b1;
        code_d[i] = exccode_ch[i];
      end
    end
  end

  always_comb begin
    ch_oh       = '0;
    ch_oh[ch_q] = 1'b1;
    cp_as       = (state_q == S_DISPATCH && kind_q == K_AS) ? ch_oh : '0;
    cp_ts       = (state_q == S_DISPATCH && kind_q == K_TS) ? ch_oh : '0;
    cp_fs       = (state_q == S_DISPATCH && kind_q == K_FS) ? ch_oh : '0;
    cp_tdata    = tdata_q;
    cpu_fvalid  = (cnt_q != '0);
    cpu_fdata   = cpu_fvalid ? mem_q[rd_q] : '0;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      kind_q  <= K_AS;
      ch_q    <= '0;
      tdata_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < NUM_CP; i++) code_q[i] <= '0;
`ifdef CP_HUB_TIMEOUT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      ch_q    <= ch_d;
      tdata_q <= tdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      mem_q   <= mem_d;
      code_q  <= code_d;
`ifdef CP_HUB_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cp_port_hub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cp_port_hub: vector table plus directed sequences for cp_port_hub.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cp_port_hub;

  logic        clk = 1'b0;
  logic        rst_;
  logic        cpu_as, cpu_ts, cpu_fs;
  logic [0:0]  cpu_sel;
  logic [31:0] cpu_tdata;
  logic        cpu_stall, cpu_fvalid;
  logic [31:0] cpu_fdata;
  logic        cpu_fack;
  logic        cpu_exc;
  logic [0:0]  cpu_exc_ch;
  logic [3:0]  cpu_exc_code;
  logic        cpu_exc_ack;
  logic [1:0]  cp_as, cp_ts, cp_fs;
  logic [31:0] cp_tdata;
  logic [1:0]  cp_abusy, cp_tbusy, cp_fbusy, cp_fds, cp_exc;
  logic [63:0] cp_fdata;
  logic [7:0]  cp_exccode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cp_port_hub #(
    .NUM_CP(2), .SEL_W(1), .DATA_W(32), .EXC_W(4), .FIFO_DEPTH(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_(rst_),
    .cpu_as(cpu_as), .cpu_ts(cpu_ts), .cpu_fs(cpu_fs),
    .cpu_sel(cpu_sel), .cpu_tdata(cpu_tdata),
    .cpu_stall(cpu_stall), .cpu_fvalid(cpu_fvalid), .cpu_fdata(cpu_fdata),
    .cpu_fack(cpu_fack),
    .cpu_exc(cpu_exc), .cpu_exc_ch(cpu_exc_ch), .cpu_exc_code(cpu_exc_code),
    .cpu_exc_ack(cpu_exc_ack),
    .cp_as(cp_as), .cp_ts(cp_ts), .cp_fs(cp_fs), .cp_tdata(cp_tdata),
    .cp_abusy(cp_abusy), .cp_tbusy(cp_tbusy), .cp_fbusy(cp_fbusy),
    .cp_fds(cp_fds), .cp_fdata(cp_fdata),
    .cp_exc(cp_exc), .cp_exccode(cp_exccode)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue fs on a channel and answer it in the dispatch cycle.
  task automatic do_fs(input logic ch, input logic [31:0] data);
    @(negedge clk);
    cpu_fs = 1'b1; cpu_sel = ch;
    @(posedge clk); #1;
    cpu_fs = 1'b0;
    cp_fds[ch] = 1'b1;
    cp_fdata[ch*32 +: 32] = data;
    @(posedge clk); #1;
    cp_fds = '0;
  endtask

  task automatic pop_chk(input string name, input logic [31:0] exp);
    chk(name, {cpu_fvalid, cpu_fdata}, {1'b1, exp});
    cpu_fack = 1'b1;
    @(posedge clk); #1;
    cpu_fack = 1'b0;
  endtask

  typedef struct {
    logic        as_, ts, fs;
    logic [0:0]  sel;
    logic [1:0]  abusy, tbusy, fbusy;
    logic [31:0] tdata;
    logic        stall;
    logic [1:0]  s_as, s_ts, s_fs;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'hDEADBEEF, 1'b0, 2'b00, 2'b10, 2'b00};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 32'h11112222, 1'b0, 2'b01, 2'b00, 2'b00};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 32'h0,        1'b1, 2'b00, 2'b00, 2'b00};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 32'h0,        1'b1, 2'b00, 2'b00, 2'b00};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 32'hCAFEF00D, 1'b0, 2'b00, 2'b01, 2'b00};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10, 32'h0,        1'b1, 2'b00, 2'b00, 2'b00};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 32'h55AA55AA, 1'b0, 2'b00, 2'b10, 2'b00};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 32'h0,        1'b1, 2'b00, 2'b00, 2'b00};

    rst_ = 1'b0;
    cpu_as = 0; cpu_ts = 0; cpu_fs = 0; cpu_sel = '0; cpu_tdata = '0;
    cpu_fack = 0; cpu_exc_ack = 0;
    cp_abusy = '0; cp_tbusy = '0; cp_fbusy = '0; cp_fds = '0; cp_fdata = '0;
    cp_exc = '0; cp_exccode = '0;

    #2;
    chk("rst_cpu", {cpu_stall, cpu_fvalid, cpu_fdata, cpu_exc, cpu_exc_ch, cpu_exc_code}, '0);
    chk("rst_cp", {cp_as, cp_ts, cp_fs, cp_tdata}, '0);
    @(negedge clk); @(negedge clk);
    rst_ = 1'b1;

    // Single-request vectors: stall in IDLE, then strobe in the following cycle.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      cpu_as = vecs[i].as_; cpu_ts = vecs[i].ts; cpu_fs = vecs[i].fs;
      cpu_sel = vecs[i].sel; cpu_tdata = vecs[i].tdata;
      cp_abusy = vecs[i].abusy; cp_tbusy = vecs[i].tbusy; cp_fbusy = vecs[i].fbusy;
      #1 chk($sformatf("v%0d_stall", i), cpu_stall, vecs[i].stall);
      @(posedge clk); #1;
      cpu_as = 0; cpu_ts = 0; cpu_fs = 0;
      chk($sformatf("v%0d_strobe", i), {cp_as, cp_ts, cp_fs}, {vecs[i].s_as, vecs[i].s_ts, vecs[i].s_fs});
      if (!vecs[i].stall) chk($sformatf("v%0d_tdata", i), cp_tdata, vecs[i].tdata);
      cp_abusy = '0; cp_tbusy = '0; cp_fbusy = '0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_strobe_gone", i), {cp_as, cp_ts, cp_fs}, '0);
    end

    // Held ts: stall only during the dispatch cycle, strobe one cycle wide.
    @(negedge clk);
    cpu_ts = 1'b1; cpu_sel = 1'b1; cpu_tdata = 32'hDEADBEEF;
    #1 chk("ts_idle_stall", cpu_stall, 1'b0);
    @(posedge clk); #1;
    chk("ts_disp", {cpu_stall, cp_ts, cp_tdata}, {1'b1, 2'b10, 32'hDEADBEEF});
    cpu_ts = 1'b0;
    @(posedge clk); #1;
    chk("ts_after", {cpu_stall, cp_ts}, {1'b0, 2'b00});

    // fs ch0 answered 3 cycles later; a stray fds on ch1 is ignored.
    @(negedge clk);
    cpu_fs = 1'b1; cpu_sel = 1'b0;
    @(posedge clk); #1;
    cpu_fs = 1'b0;
    chk("fs_strobe", cp_fs, 2'b01);
    cp_fds = 2'b10; cp_fdata = {32'hBADBAD00, 32'h0};
    @(posedge clk); #1;
    cp_fds = 2'b00;
    chk("fs_stray_ignored", cpu_fvalid, 1'b0);
    cp_fds = 2'b01; cp_fdata = {32'h0, 32'h12345678};
    @(posedge clk); #1;
    cp_fds = 2'b00;
    pop_chk("fs_data", 32'h12345678);
    chk("fs_empty", cpu_fvalid, 1'b0);
    cpu_fack = 1'b1;
    @(posedge clk); #1;
    cpu_fack = 1'b0;
    chk("fack_empty_ignored", cpu_fvalid, 1'b0);

    // Fill FIFO, fifth fs stalls until one pop, order preserved.
    for (int i = 0; i < 4; i++) do_fs(1'b0, 32'hA0 + 32'(i));
    @(negedge clk);
    cpu_fs = 1'b1; cpu_sel = 1'b0;
    #1 chk("full_stall", cpu_stall, 1'b1);
    @(posedge clk); #1;
    chk("full_stall_held", {cpu_stall, cp_fs}, {1'b1, 2'b00});
    pop_chk("pop0", 32'hA0);
    chk("full_released", cpu_stall, 1'b0);
    @(posedge clk); #1;
    cpu_fs = 1'b0;
    chk("fifth_strobe", cp_fs, 2'b01);
    cp_fds = 2'b01; cp_fdata = {32'h0, 32'hA4};
    @(posedge clk); #1;
    cp_fds = 2'b00;
    for (int i = 1; i < 5; i++) pop_chk($sformatf("pop%0d", i), 32'hA0 + 32'(i));
    chk("fifo_drained", cpu_fvalid, 1'b0);

    // as ch1 held against busy, strobe follows busy release.
    @(negedge clk);
    cpu_as = 1'b1; cpu_sel = 1'b1; cp_abusy = 2'b10;
    @(posedge clk); #1;
    chk("abusy_hold", {cpu_stall, cp_as}, {1'b1, 2'b00});
    @(posedge clk); #1;
    chk("abusy_hold2", {cpu_stall, cp_as}, {1'b1, 2'b00});
    cp_abusy = 2'b00;
    @(posedge clk); #1;
    cpu_as = 1'b0;
    chk("abusy_released", cp_as, 2'b10);
    @(posedge clk); #1;

    // Simultaneous exceptions: lowest index first.
    @(negedge clk);
    cp_exc = 2'b11; cp_exccode = {4'd3, 4'd5};
    #1 chk("exc_not_yet", cpu_exc, 1'b0);
    @(posedge clk); #1;
    cp_exc = 2'b00;
    chk("exc_ch0", {cpu_exc, cpu_exc_ch, cpu_exc_code}, {1'b1, 1'b0, 4'd5});
    cpu_exc_ack = 1'b1;
    @(posedge clk); #1;
    cpu_exc_ack = 1'b0;
    chk("exc_ch1", {cpu_exc, cpu_exc_ch, cpu_exc_code}, {1'b1, 1'b1, 4'd3});
    cpu_exc_ack = 1'b1;
    @(posedge clk); #1;
    cpu_exc_ack = 1'b0;
    chk("exc_clear", cpu_exc, 1'b0);

    // New exception in the ack cycle wins and overwrites the code.
    cp_exc = 2'b01; cp_exccode = {4'd0, 4'd7};
    @(posedge clk); #1;
    cp_exc = 2'b01; cp_exccode = {4'd0, 4'd9}; cpu_exc_ack = 1'b1;
    @(posedge clk); #1;
    cp_exc = 2'b00; cpu_exc_ack = 1'b0;
    chk("exc_ack_race", {cpu_exc, cpu_exc_ch, cpu_exc_code}, {1'b1, 1'b0, 4'd9});
    cpu_exc_ack = 1'b1;
    @(posedge clk); #1;
    cpu_exc_ack = 1'b0;
    chk("exc_race_clear", cpu_exc, 1'b0);

`ifdef CP_HUB_TIMEOUT_EN
    // fs ch1 never answered: exception after 8 WAIT_FDS cycles.
    @(negedge clk);
    cpu_fs = 1'b1; cpu_sel = 1'b1;
    @(posedge clk); #1;
    cpu_fs = 1'b0;
    for (int i = 0; i < 8; i++) @(posedge clk);
    #1 chk("tmo_not_yet", cpu_exc, 1'b0);
    @(posedge clk); #1;
    chk("tmo_exc", {cpu_exc, cpu_exc_ch, cpu_exc_code, cpu_fvalid}, {1'b1, 1'b1, 4'hF, 1'b0});
    cpu_exc_ack = 1'b1;
    @(posedge clk); #1;
    cpu_exc_ack = 1'b0;
    chk("tmo_cleared", {cpu_exc, cpu_stall}, 2'b00);
`endif

    // Asynchronous reset mid-dispatch drops strobe and FIFO contents.
    do_fs(1'b1, 32'h77778888);
    @(negedge clk);
    cpu_ts = 1'b1; cpu_sel = 1'b1; cpu_tdata = 32'h0BADF00D;
    @(posedge clk); #1;
    cpu_ts = 1'b0;
    chk("pre_rst", {cp_ts, cpu_fvalid}, {2'b10, 1'b1});
    rst_ = 1'b0;
    #1 chk("async_rst", {cp_ts, cp_tdata, cpu_fvalid, cpu_fdata}, '0);
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk); #1;
    chk("post_rst", {cp_ts, cpu_fvalid, cpu_stall}, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cp_port_hub.md
# cp_port_hub

Multi-channel coprocessor transfer hub between the CPU's single coprocessor port and up to NUM_CP coprocessors. It accepts arithmetic-start, transfer-to and transfer-from requests addressed by channel number. It dispatches each request as a one-cycle strobe to the selected coprocessor and buffers returned data in a response FIFO. It also latches per-channel exceptions, with an optional response timeout. It sits beside the CPU pipeline and replaces the single-channel cp2 strobe/busy wiring at the CPU top.

## Interface
Parameters:
- NUM_CP, 2, number of coprocessor channels; 2..2**SEL_W
- SEL_W, 1, width of the channel select
- DATA_W, 32, data word width
- EXC_W, 4, exception code width
- FIFO_DEPTH, 4, response FIFO entries; power of two, ≥2
- TIMEOUT, 255, maximum WAIT_FDS cycles; 1..65535

Ports:
- clk  in  1  clock; all state is updated on the rising edge
- rst_  in  1  asynchronous active-low reset
- cpu_as / cpu_ts / cpu_fs  in  1 each  request arithmetic start / transfer-to / transfer-from
- cpu_sel  in  SEL_W  target channel
- cpu_tdata  in  DATA_W  transfer-to data
- cpu_stall  out  1  request not accepted this cycle
- cpu_fvalid  out  1  response FIFO non-empty
- cpu_fdata  out  DATA_W  FIFO head data
- cpu_fack  in  1  pop FIFO head
- cpu_exc  out  1  exception pending
- cpu_exc_ch  out  SEL_W  channel of the reported exception
- cpu_exc_code  out  EXC_W  code of the reported exception
- cpu_exc_ack  in  1  clear the reported exception
- cp_as / cp_ts / cp_fs  out  NUM_CP each  per-channel strobes
- cp_tdata  out  DATA_W  broadcast transfer-to data
- cp_abusy / cp_tbusy / cp_fbusy  in  NUM_CP each  per-channel busy
- cp_fds  in  NUM_CP  per-channel from-data valid
- cp_fdata  in  NUM_CP*DATA_W  per-channel data; channel i occupies bits [i*DATA_W +: DATA_W]
- cp_exc  in  NUM_CP  per-channel exception pulse
- cp_exccode  in  NUM_CP*EXC_W  per-channel codes

## Operation
- FSM states: IDLE, DISPATCH, WAIT_FDS.
- Request kind: when more than one of cpu_fs, cpu_ts, cpu_as is asserted, fs takes priority over ts, and ts over as.
- cpu_stall (combinational) = request present AND (state≠IDLE OR cpu_sel≥NUM_CP OR the selected channel's busy for that kind OR (fs AND FIFO full)).
- Acceptance: in IDLE, a request with cpu_stall=0 latches kind, channel and cpu_tdata, then moves to DISPATCH.
- DISPATCH: exactly one cp_* strobe bit is high for that channel, and cp_tdata holds the latched data. Next state is WAIT_FDS for fs, else IDLE.
- fds handling: cp_fds[ch] from the latched channel in DISPATCH or WAIT_FDS pushes its cp_fdata slice into the FIFO and moves to IDLE. cp_fds from any other channel, or in IDLE, is ignored.
- FIFO: a pop (cpu_fack with cpu_fvalid) removes the head. cpu_fack while empty is ignored. Push and pop in the same cycle keep the count unchanged. Pointers wrap modulo FIFO_DEPTH. A push never sees a full FIFO, because fs is gated on full.
- Exceptions: cp_exc[i] sets pending[i] and stores code[i]; a later exception on the same channel overwrites the code. The lowest pending index is reported. cpu_exc_ack clears the reported entry; a new cp_exc on the same channel in the same cycle wins, leaving it set.
- Reset: state IDLE, FIFO empty, pending cleared. All outputs are 0: cpu_stall, cpu_fvalid, cpu_fdata, cpu_exc, cpu_exc_ch, cpu_exc_code, all cp_* strobes, cp_tdata.

## Timing
- A request accepted at edge T drives its strobe during cycle T+1 (registered).
- ts/as: cpu_stall is high in cycle T+1 (DISPATCH). Back-to-back acceptance occurs every 2 cycles.
- fs: an fds seen at edge R drives cpu_fvalid/cpu_fdata valid from R+1. Minimum fs-to-data latency is 2 cycles.
- cpu_exc becomes valid the cycle after a cp_exc edge. An ack at edge A drops the entry at A+1.
- Asserting rst_ mid-transaction takes effect immediately: strobes drop and FIFO contents are lost.

## Configuration
- CP_HUB_TIMEOUT_EN defined: a counter is cleared on entry to WAIT_FDS and increments each WAIT_FDS cycle. When it reaches TIMEOUT, the hub sets pending[ch] with code all-ones, pushes nothing and returns to IDLE.
- CP_HUB_TIMEOUT_EN undefined: there is no counter, and WAIT_FDS waits indefinitely.

## Test plan
- Reset, then ts ch1 with tdata=0xDEADBEEF: cp_ts=2'b10 for exactly one cycle with cp_tdata=0xDEADBEEF; cpu_stall=1 only in the dispatch cycle.
- fs ch0 with cp_fds[0] 3 cycles later and data 0x12345678: cpu_fvalid=1 with 0x12345678 one cycle after fds; cpu_fack empties the FIFO.
- Issue fs ch0 four times, each answered, with no pops (FIFO_DEPTH=4): the fifth fs has cpu_stall=1 until one cpu_fack. Pop order returns the data in issue order.
- cp_abusy[1]=1 while as ch1 is requested: cpu_stall=1 and no strobe. Drop busy: the strobe appears the following cycle.
- cp_exc on ch1 (code 3) and ch0 (code 5) in the same cycle: the hub reports ch0/5; after ack it reports ch1/3; after a second ack cpu_exc=0.
- With CP_HUB_TIMEOUT_EN and TIMEOUT=8, issue fs ch1 with no fds: after 8 WAIT_FDS cycles cpu_exc=1 with ch=1, code=4'hF; the FIFO stays empty.
